// File: rtl/bus_arb_pkg.sv
// ============================================================================
// bus_arb_pkg: shared types and defaults for the tri-state bus arbiter. Rev 1.0
// ============================================================================
`default_nettype none

package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    TURNAROUND = 2'd2
  } arb_state_e;

  localparam int DEFAULT_N_MASTERS = 3;
  localparam int DEFAULT_MAX_HOLD  = 16;
  localparam int BUS_SEL_NONE      = 0;
  localparam int HOLD_W            = 8;

  // Index width that stays legal for a single-master build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick: combinational round-robin winner search starting after 'last'. Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N_MASTERS,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

  logic [IDX_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = last;
    // Walk last+1, last+2, ... with wrap; the first requester found wins.
    for (int k = 0; k < N; k++) begin
      idx = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter: round-robin tri-state bus arbiter with hold limit and turnaround. Rev 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = DEFAULT_N_MASTERS,
  parameter int MAX_HOLD  = DEFAULT_MAX_HOLD
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_MASTERS-1:0]               req,
  input  logic [N_MASTERS-1:0]               done,
  output logic [N_MASTERS-1:0]               grant,
  output logic [$clog2(N_MASTERS+1)-1:0]     bus_sel,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int SEL_W = $clog2(N_MASTERS + 1);
  localparam int IDX_W = idx_width(N_MASTERS);

  localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(N_MASTERS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [SEL_W-1:0]  SEL_NONE   = SEL_W'(BUS_SEL_NONE);

  arb_state_e             state, state_d;
  logic [N_MASTERS-1:0]   grant_d;
  logic [SEL_W-1:0]       sel_d;
  logic                   tmo_d;
  logic [HOLD_W-1:0]      hold_cnt, hold_d;
  logic [IDX_W-1:0]       last, last_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   release_now;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // While granted, 'last' is the current owner.
  assign release_now = done[last] | ~req[last];

  always_comb begin
    state_d = state;
    grant_d = grant;
    sel_d   = bus_sel;
    tmo_d   = 1'b0;
    hold_d  = hold_cnt;
    last_d  = last;

    unique case (state)
      IDLE, TURNAROUND: begin
        if (pick_valid) begin
          state_d           = GRANTED;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          sel_d             = SEL_W'(pick_idx) + SEL_W'(1);
          hold_d            = HOLD_W'(1);
          last_d            = pick_idx;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = SEL_NONE;
          hold_d  = '0;
        end
      end

      GRANTED: begin
        if (release_now || hold_cnt == HOLD_LIMIT) begin
          state_d = TURNAROUND;
          grant_d = '0;
          sel_d   = SEL_NONE;
          hold_d  = '0;
          // A release in the limit cycle wins over the timeout.
          tmo_d   = ~release_now;
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = SEL_NONE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      bus_sel     <= SEL_NONE;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      last        <= LAST_RESET;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      bus_sel     <= sel_d;
      timeout_err <= tmo_d;
      hold_cnt    <= hold_d;
      last        <= last_d;
    end
  end

  assign busy = |grant;

endmodule

`default_nettype wire
